// File: rtl/dcache_control.sv
// Control FSM for a 2-way set-associative data cache with write-back, write-allocate policy.
// Drives the tag/valid/dirty/LRU arrays and the 256-bit line data enables.
module dcache_control #(
    parameter int s_index = 5,
    parameter int s_mask  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_mask-1:0] mem_byte_enable256,
    output logic              mem_resp,

    input  logic [1:0]        hit_datapath,
    input  logic [1:0]        valid_out,
    input  logic [1:0]        dirty_out,
    input  logic              lru_output,

    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,

    output logic [s_mask-1:0] write_enable_0,
    output logic [s_mask-1:0] write_enable_1,
    output logic              mem_enable_sel,
    output logic              set_lru,
    output logic              load_lru,
    output logic [1:0]        load_tag,
    output logic [1:0]        load_valid,
    output logic [1:0]        set_valid,
    output logic [1:0]        load_dirty,
    output logic [1:0]        set_dirty
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        SETTLE
    } state_t;

    state_t state;
    logic   victim;
    logic   request;
    logic   hit_way;

    assign request = mem_read | mem_write;
    // Way 0 wins if both ways report a hit.
    assign hit_way = ~hit_datapath[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) state <= LOOKUP;
                end
                LOOKUP: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (hit_datapath != 2'b00) begin
                        state <= IDLE;
                    end else begin
                        victim <= lru_output;
                        if (valid_out[lru_output] && dirty_out[lru_output])
                            state <= WRITEBACK;
                        else
                            state <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) state <= SETTLE;
                end
                SETTLE: begin
                    state <= LOOKUP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        write_enable_0 = '0;
        write_enable_1 = '0;
        mem_enable_sel = 1'b0;
        set_lru        = 1'b0;
        load_lru       = 1'b0;
        load_tag       = 2'b00;
        load_valid     = 2'b00;
        set_valid      = 2'b00;
        load_dirty     = 2'b00;
        set_dirty      = 2'b00;

        unique case (state)
            LOOKUP: begin
                if (request && (hit_datapath != 2'b00)) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    set_lru  = ~hit_way;
                    // A combined read+write request is treated as a write.
                    if (mem_write) begin
                        if (hit_way)
                            write_enable_1 = mem_byte_enable256;
                        else
                            write_enable_0 = mem_byte_enable256;
                        load_dirty[hit_way] = 1'b1;
                        set_dirty[hit_way]  = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
            end
            FILL: begin
                pmem_read      = 1'b1;
                mem_enable_sel = 1'b1;
                // The returning line lands in the victim way as clean and valid.
                if (pmem_resp) begin
                    if (victim)
                        write_enable_1 = '1;
                    else
                        write_enable_0 = '1;
                    load_tag[victim]   = 1'b1;
                    load_valid[victim] = 1'b1;
                    set_valid[victim]  = 1'b1;
                    load_dirty[victim] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
